// File: rtl/alu_result_collector.sv
// Selects the lowest-index valid execution-unit result and buffers it, with its unit ID, in a
// first-word fall-through ring. Sticky collision/overflow flags. `ALU_RESULT_CNT_EN adds a
// saturating pop counter on RESULT_CNT.
module alu_result_collector #(
    parameter int N_UNITS   = 4,
    parameter int OUT_WIDTH = 32,
    parameter int DEPTH     = 2,
    parameter int ID_WIDTH  = 2
`ifdef ALU_RESULT_CNT_EN
    , parameter int CNT_WIDTH = 16
`endif
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [N_UNITS*OUT_WIDTH-1:0]  UNIT_DATA,
    input  logic [N_UNITS-1:0]            UNIT_VALID,
    output logic                          IN_READY,
    output logic signed [OUT_WIDTH-1:0]   ALU_OUT,
    output logic [ID_WIDTH-1:0]           UNIT_ID,
    output logic                          OUT_Valid,
    input  logic                          OUT_READY,
    input  logic                          ERR_CLR,
    output logic                          ERR_COLLISION,
    output logic                          ERR_OVERFLOW
`ifdef ALU_RESULT_CNT_EN
    , output logic [CNT_WIDTH-1:0]        RESULT_CNT
`endif
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FILL_W = PTR_W + 1;

    logic [OUT_WIDTH-1:0] data_mem [DEPTH];
    logic [ID_WIDTH-1:0]  id_mem   [DEPTH];
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;
    logic [FILL_W-1:0]    fill;

    logic                 any_valid;
    logic                 multi_valid;
    logic                 push;
    logic                 pop;
    logic [OUT_WIDTH-1:0] win_data;
    logic [ID_WIDTH-1:0]  win_id;

    // Lowest index wins: scan downward so the last assignment is the lowest set bit.
    always_comb begin
        win_id   = '0;
        win_data = '0;
        for (int i = N_UNITS - 1; i >= 0; i--) begin
            if (UNIT_VALID[i]) begin
                win_id   = ID_WIDTH'(i);
                win_data = UNIT_DATA[i*OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

    assign any_valid   = |UNIT_VALID;
    assign multi_valid = |(UNIT_VALID & (UNIT_VALID - N_UNITS'(1)));

    // Handshake: an entry moves on any edge where its valid and ready are both high. IN_READY
    // depends only on the registered fill level, so a same-cycle pop never frees a slot for a push.
    assign IN_READY  = (fill != FILL_W'(DEPTH));
    assign OUT_Valid = (fill != '0);
    assign push      = any_valid & IN_READY;
    assign pop       = OUT_Valid & OUT_READY;

    assign ALU_OUT = OUT_Valid ? data_mem[rd_ptr] : '0;
    assign UNIT_ID = OUT_Valid ? id_mem[rd_ptr]   : '0;

    always_ff @(posedge CLK) begin
        if (push) begin
            data_mem[wr_ptr] <= win_data;
            id_mem[wr_ptr]   <= win_id;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      fill <= fill + FILL_W'(1);
            else if (pop && !push) fill <= fill - FILL_W'(1);
        end
    end

    // A new error event outranks a clear on the same edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ERR_COLLISION <= 1'b0;
            ERR_OVERFLOW  <= 1'b0;
        end else begin
            ERR_COLLISION <= multi_valid | (ERR_COLLISION & ~ERR_CLR);
            ERR_OVERFLOW  <= (any_valid & ~IN_READY) | (ERR_OVERFLOW & ~ERR_CLR);
        end
    end

`ifdef ALU_RESULT_CNT_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            RESULT_CNT <= '0;
        end else if (ERR_CLR) begin
            RESULT_CNT <= '0;
        end else if (pop && (RESULT_CNT != '1)) begin
            RESULT_CNT <= RESULT_CNT + CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_alu_result_collector.sv
// Directed bench for alu_result_collector: queue-based reference model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_alu_result_collector;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int D  = 2;
  localparam int IW = 2;
`ifdef ALU_RESULT_CNT_EN
  localparam int CW = 2;
`endif

  logic            CLK = 1'b0;
  logic            RST = 1'b0;
  logic [N*W-1:0]  UNIT_DATA = '0;
  logic [N-1:0]    UNIT_VALID = '0;
  logic            IN_READY;
  logic [W-1:0]    ALU_OUT;
  logic [IW-1:0]   UNIT_ID;
  logic            OUT_Valid;
  logic            OUT_READY = 1'b0;
  logic            ERR_CLR = 1'b0;
  logic            ERR_COLLISION;
  logic            ERR_OVERFLOW;
`ifdef ALU_RESULT_CNT_EN
  logic [CW-1:0]   RESULT_CNT;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  alu_result_collector #(
    .N_UNITS(N), .OUT_WIDTH(W), .DEPTH(D), .ID_WIDTH(IW)
`ifdef ALU_RESULT_CNT_EN
    , .CNT_WIDTH(CW)
`endif
  ) dut (
    .CLK(CLK), .RST(RST), .UNIT_DATA(UNIT_DATA), .UNIT_VALID(UNIT_VALID),
    .IN_READY(IN_READY), .ALU_OUT(ALU_OUT), .UNIT_ID(UNIT_ID), .OUT_Valid(OUT_Valid),
    .OUT_READY(OUT_READY), .ERR_CLR(ERR_CLR), .ERR_COLLISION(ERR_COLLISION),
    .ERR_OVERFLOW(ERR_OVERFLOW)
`ifdef ALU_RESULT_CNT_EN
    , .RESULT_CNT(RESULT_CNT)
`endif
  );

  // clock / reset
  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  logic [IW+W-1:0] exp_q[$];
  logic            m_col = 1'b0;
  logic            m_ovf = 1'b0;
  int              m_cnt = 0;
  int              m_ones;
  int              m_first;
  bit              m_full;
  bit              m_pop;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      exp_q.delete();
      m_col = 1'b0;
      m_ovf = 1'b0;
      m_cnt = 0;
    end else begin
      m_ones  = $countones(UNIT_VALID);
      m_full  = (exp_q.size() >= D);
      m_pop   = (exp_q.size() != 0) && OUT_READY;
      m_first = -1;
      for (int i = 0; i < N && m_first < 0; i++)
        if (UNIT_VALID[i]) m_first = i;
      if (m_pop) void'(exp_q.pop_front());
      if (m_ones > 0 && !m_full)
        exp_q.push_back({IW'(m_first), UNIT_DATA[m_first*W +: W]});
      m_col = (m_ones > 1) || (m_col && !ERR_CLR);
      m_ovf = (m_ones > 0 && m_full) || (m_ovf && !ERR_CLR);
`ifdef ALU_RESULT_CNT_EN
      if (ERR_CLR) m_cnt = 0;
      else if (m_pop && m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
`endif
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard compare, every cycle on the falling edge
  always @(negedge CLK) begin
    check("m_valid", 64'(OUT_Valid), 64'(exp_q.size() != 0));
    check("m_in_ready", 64'(IN_READY), 64'(exp_q.size() < D));
    check("m_alu_out", 64'(ALU_OUT), (exp_q.size() != 0) ? 64'(exp_q[0][W-1:0]) : 64'd0);
    check("m_unit_id", 64'(UNIT_ID), (exp_q.size() != 0) ? 64'(exp_q[0][IW+W-1:W]) : 64'd0);
    check("m_err_col", 64'(ERR_COLLISION), 64'(m_col));
    check("m_err_ovf", 64'(ERR_OVERFLOW), 64'(m_ovf));
`ifdef ALU_RESULT_CNT_EN
    check("m_cnt", 64'(RESULT_CNT), 64'(m_cnt));
`endif
  end

  // ---------------- driver ----------------
  // Apply inputs (called just after a rising edge), then advance one edge and settle.
  task automatic drive(input logic [N-1:0] v, input logic [W-1:0] d0, input logic [W-1:0] d1,
                       input logic [W-1:0] d2, input logic [W-1:0] d3,
                       input logic rdy, input logic clr);
    UNIT_VALID = v;
    UNIT_DATA  = {d3, d2, d1, d0};
    OUT_READY  = rdy;
    ERR_CLR    = clr;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input logic rdy, input logic clr);
    drive('0, '0, '0, '0, '0, rdy, clr);
  endtask

  logic [W-1:0] held;

  initial begin
    // reset
    repeat (3) @(posedge CLK);
    #1;
    check("rst_valid", 64'(OUT_Valid), 64'd0);
    check("rst_in_ready", 64'(IN_READY), 64'd1);
    check("rst_alu_out", 64'(ALU_OUT), 64'd0);
    check("rst_errs", 64'({ERR_COLLISION, ERR_OVERFLOW}), 64'd0);
    RST = 1'b1;
    @(posedge CLK);
    #1;

    // single result from unit 2
    drive(4'b0100, 0, 0, 32'h0000_00A5, 0, 1'b1, 1'b0);
    check("single_valid", 64'(OUT_Valid), 64'd1);
    check("single_data", 64'(ALU_OUT), 64'h0000_00A5);
    check("single_id", 64'(UNIT_ID), 64'd2);
    idle(1'b1, 1'b0);
    check("single_drained", 64'(OUT_Valid), 64'd0);

    // collision: unit1 wins over unit3
    drive(4'b1010, 0, 32'd7, 0, 32'd9, 1'b0, 1'b0);
    check("col_data", 64'(ALU_OUT), 64'd7);
    check("col_id", 64'(UNIT_ID), 64'd1);
    check("col_flag", 64'(ERR_COLLISION), 64'd1);
    idle(1'b1, 1'b0);
    check("col_sticky", 64'(ERR_COLLISION), 64'd1);
    idle(1'b0, 1'b1);
    check("col_cleared", 64'(ERR_COLLISION), 64'd0);

    // overflow with consumer stalled
    drive(4'b0001, 32'd1, 0, 0, 0, 1'b0, 1'b0);
    check("ovf_ready1", 64'(IN_READY), 64'd1);
    drive(4'b0001, 32'd2, 0, 0, 0, 1'b0, 1'b0);
    check("ovf_ready2", 64'(IN_READY), 64'd0);
    drive(4'b0001, 32'd3, 0, 0, 0, 1'b0, 1'b0);
    check("ovf_flag", 64'(ERR_OVERFLOW), 64'd1);
    check("ovf_head", 64'(ALU_OUT), 64'd1);
    idle(1'b1, 1'b0);
    check("ovf_second", 64'(ALU_OUT), 64'd2);
    idle(1'b1, 1'b0);
    check("ovf_empty", 64'(OUT_Valid), 64'd0);
    idle(1'b0, 1'b1);
    check("ovf_cleared", 64'(ERR_OVERFLOW), 64'd0);

    // same-cycle push and pop with pointer wrap
    drive(4'b0001, 32'h11, 0, 0, 0, 1'b0, 1'b0);
    drive(4'b1000, 0, 0, 0, 32'h55, 1'b1, 1'b0);
    check("pp_head", 64'(ALU_OUT), 64'h55);
    check("pp_id", 64'(UNIT_ID), 64'd3);
    check("pp_ready", 64'(IN_READY), 64'd1);
    for (int i = 0; i < 2 * D + 1; i++) begin
      drive(4'b1000, 0, 0, 0, 32'h100 + i, 1'b1, 1'b0);
      check("pp_wrap", 64'(ALU_OUT), 64'(32'h100 + i));
    end
    idle(1'b1, 1'b0);
    check("pp_drained", 64'(OUT_Valid), 64'd0);

    // error set wins over a coincident clear
    drive(4'b0011, 32'd4, 32'd5, 0, 0, 1'b1, 1'b1);
    check("setwins_col", 64'(ERR_COLLISION), 64'd1);
    check("setwins_data", 64'(ALU_OUT), 64'd4);
    idle(1'b1, 1'b1);

    // negative result held, then async reset mid-hold
    drive(4'b0001, 32'hFFFF_FFF0, 0, 0, 0, 1'b0, 1'b0);
    held = ALU_OUT;
    check("neg_data", 64'(held), 64'hFFFF_FFF0);
    for (int i = 0; i < 3; i++) begin
      idle(1'b0, 1'b0);
      check("neg_hold", 64'(ALU_OUT), 64'hFFFF_FFF0);
    end
    RST = 1'b0;
    #1;
    check("arst_valid", 64'(OUT_Valid), 64'd0);
    check("arst_data", 64'(ALU_OUT), 64'd0);
    check("arst_ready", 64'(IN_READY), 64'd1);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    #1;

`ifdef ALU_RESULT_CNT_EN
    // saturating pop counter: 1, 2, 3, 3, 3 then cleared
    drive(4'b0001, 32'd20, 0, 0, 0, 1'b1, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      if (k < 5) drive(4'b0001, 32'd20 + k, 0, 0, 0, 1'b1, 1'b0);
      else       idle(1'b1, 1'b0);
      check("cnt_step", 64'(RESULT_CNT), 64'((k < 3) ? k : 3));
    end
    idle(1'b0, 1'b1);
    check("cnt_clear", 64'(RESULT_CNT), 64'd0);
`endif

    idle(1'b0, 1'b0);
    @(posedge CLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
